// File: rtl/regfile_param.sv
// regfile_param: parameterised register file with a scoreboard busy bit per
// register. After reset the array is walked one entry per cycle and zeroed;
// only then does the file report ready and accept writes or issues.
// Reads are combinational, with optional same-cycle write forwarding.

module regfile_param #(
  parameter int WIDTH     = 32,
  parameter int ADDR_BITS = 5,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] rs,
  input  logic [ADDR_BITS-1:0] rt,
  input  logic [ADDR_BITS-1:0] rd,
  input  logic [WIDTH-1:0]     busW,
  input  logic                 writeEnable,
  input  logic                 issueEnable,
  input  logic [ADDR_BITS-1:0] issueReg,
  output logic [WIDTH-1:0]     busA,
  output logic [WIDTH-1:0]     busB,
  output logic                 busyA,
  output logic                 busyB,
  output logic                 ready
);

  localparam int DEPTH = 2 ** ADDR_BITS;

  localparam logic [ADDR_BITS-1:0] PTR_ZERO = {ADDR_BITS{1'b0}};
  localparam logic [ADDR_BITS-1:0] PTR_ONE  = ADDR_BITS'(32'd1);
  localparam logic [ADDR_BITS-1:0] PTR_LAST = {ADDR_BITS{1'b1}};
  localparam logic [WIDTH-1:0]     DATA_ZERO = {WIDTH{1'b0}};

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t               state_r;
  state_t               stateNext_s;
  logic [ADDR_BITS-1:0] clearPtr_r;
  logic [ADDR_BITS-1:0] clearPtrNext_s;
  logic                 ready_r;
  logic [DEPTH-1:0]     busy_r;
  logic [DEPTH-1:0]     busyNext_s;
  logic [WIDTH-1:0]     regs_r [DEPTH];

  logic                 running_s;
  logic                 writeKill_s;
  logic                 writeOk_s;
  logic                 rsZero_s;
  logic                 rtZero_s;
  logic [WIDTH-1:0]     busA_s;
  logic [WIDTH-1:0]     busB_s;
  logic                 busyA_s;
  logic                 busyB_s;

  // True when the address names the hardwired zero register.
  function automatic logic isZeroReg(input logic [ADDR_BITS-1:0] addr);
    return (ZERO_REG != 0) && (addr == PTR_ZERO);
  endfunction

  // Qualify the write port: only in RUN, and never into the hardwired zero register.
  always_comb begin
    running_s   = (state_r == RUN);
    writeKill_s = isZeroReg(rd);
    rsZero_s    = isZeroReg(rs);
    rtZero_s    = isZeroReg(rt);
    writeOk_s   = running_s && writeEnable && !writeKill_s;
  end

  // Next-state logic: walk the clear pointer through every entry, then run.
  always_comb begin
    stateNext_s    = state_r;
    clearPtrNext_s = clearPtr_r;
    case (state_r)
      CLEAR: begin
        if (clearPtr_r == PTR_LAST) begin
          stateNext_s    = RUN;
          clearPtrNext_s = PTR_ZERO;
        end else begin
          stateNext_s    = CLEAR;
          clearPtrNext_s = clearPtr_r + PTR_ONE;
        end
      end
      RUN: begin
        stateNext_s    = RUN;
        clearPtrNext_s = clearPtr_r;
      end
      default: begin
        stateNext_s    = CLEAR;
        clearPtrNext_s = PTR_ZERO;
      end
    endcase
  end

  // Scoreboard update: the write clears, the issue sets afterwards so set wins.
  always_comb begin
    busyNext_s = busy_r;
    if (running_s) begin
      if (writeEnable) begin
        busyNext_s[rd] = 1'b0;
      end else begin
        busyNext_s[rd] = busy_r[rd];
      end
      if (issueEnable) begin
        busyNext_s[issueReg] = 1'b1;
      end else begin
        busyNext_s[issueReg] = busyNext_s[issueReg];
      end
    end else begin
      busyNext_s = {DEPTH{1'b0}};
    end
    if (ZERO_REG != 0) begin
      busyNext_s[0] = 1'b0;
    end else begin
      busyNext_s[0] = busyNext_s[0];
    end
  end

  // Control state, clear pointer, ready flag and busy bits, with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= CLEAR;
      clearPtr_r <= PTR_ZERO;
      ready_r    <= 1'b0;
      busy_r     <= {DEPTH{1'b0}};
    end else begin
      state_r    <= stateNext_s;
      clearPtr_r <= clearPtrNext_s;
      ready_r    <= (stateNext_s == RUN);
      busy_r     <= busyNext_s;
    end
  end

  // Storage array: zeroed entry by entry during CLEAR, written from busW in RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs_r[clearPtr_r] <= regs_r[clearPtr_r];
    end else if (state_r == CLEAR) begin
      regs_r[clearPtr_r] <= DATA_ZERO;
    end else if (writeOk_s) begin
      regs_r[rd] <= busW;
    end else begin
      regs_r[rd] <= regs_r[rd];
    end
  end

  // Source-1 read path: masked in CLEAR, zero register, then forwarding, then array.
  always_comb begin
    busA_s = DATA_ZERO;
    if (!running_s) begin
      busA_s = DATA_ZERO;
    end else if (rsZero_s) begin
      busA_s = DATA_ZERO;
    end else if ((BYPASS != 0) && writeOk_s && (rd == rs)) begin
      busA_s = busW;
    end else begin
      busA_s = regs_r[rs];
    end
  end

  // Source-2 read path: same priority as source 1.
  always_comb begin
    busB_s = DATA_ZERO;
    if (!running_s) begin
      busB_s = DATA_ZERO;
    end else if (rtZero_s) begin
      busB_s = DATA_ZERO;
    end else if ((BYPASS != 0) && writeOk_s && (rd == rt)) begin
      busB_s = busW;
    end else begin
      busB_s = regs_r[rt];
    end
  end

  // Busy lookups: straight from the scoreboard, never forwarded, masked in CLEAR.
  always_comb begin
    busyA_s = 1'b0;
    busyB_s = 1'b0;
    if (running_s) begin
      busyA_s = busy_r[rs];
      busyB_s = busy_r[rt];
    end else begin
      busyA_s = 1'b0;
      busyB_s = 1'b0;
    end
  end

  assign busA  = busA_s;
  assign busB  = busB_s;
  assign busyA = busyA_s;
  assign busyB = busyB_s;
  assign ready = ready_r;

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits.
REQ-002 Parameter ADDR_BITS, default 5, register index width; DEPTH = 2**ADDR_BITS registers.
REQ-003 Parameter ZERO_REG, default 1, register 0 hardwired to zero when 1.
REQ-004 Parameter BYPASS, default 1, write-to-read forwarding enabled when 1.
REQ-005 The block SHALL have one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 rs  input  ADDR_BITS  source-1 register number, drives busA.
REQ-009 rt  input  ADDR_BITS  source-2 register number, drives busB.
REQ-010 rd  input  ADDR_BITS  destination register number.
REQ-011 busW  input  WIDTH  write data.
REQ-012 writeEnable  input  1  write busW to rd at the next edge; also clears busy[rd].
REQ-013 issueEnable  input  1  mark issueReg busy at the next edge.
REQ-014 issueReg  input  ADDR_BITS  register claimed by an in-flight producer.
REQ-015 busA  output  WIDTH  read data for rs.
REQ-016 busB  output  WIDTH  read data for rt.
REQ-017 busyA  output  1  busy bit of rs.
REQ-018 busyB  output  1  busy bit of rt.
REQ-019 ready  output  1  high when the clear sequence is complete and the file accepts writes.

Function
REQ-020 Two-state FSM, CLEAR and RUN: reset forces CLEAR with clear pointer 0; CLEAR goes to RUN after the edge that clears register DEPTH-1.
REQ-021 In CLEAR, one register per cycle, indexed by the pointer, SHALL be written to 0; the pointer increments by 1; clearing takes DEPTH cycles after reset deasserts.
REQ-022 ready SHALL be 0 in CLEAR and 1 in RUN; registered (state-decoded, no combinational path from inputs).
REQ-023 In CLEAR, writeEnable and issueEnable SHALL be ignored; busA, busB, busyA and busyB SHALL read 0.
REQ-024 In RUN, writeEnable=1 SHALL store busW into reg[rd] at the rising edge; latency from edge to stored value is 1 cycle.
REQ-025 Reads SHALL be combinational: busA = reg[rs] and busB = reg[rt], with no clock latency.
REQ-026 With ZERO_REG=1, writes to rd=0 SHALL be discarded, reads of register 0 SHALL return 0, and busy[0] SHALL stay 0.
REQ-027 With BYPASS=1, in RUN with writeEnable=1 and rd==rs (rd!=0 if ZERO_REG), busA SHALL equal busW in the same cycle; likewise busB for rt.
REQ-028 With BYPASS=0, a same-cycle read of rd SHALL return the old value.
REQ-029 Scoreboard: issueEnable=1 SHALL set busy[issueReg]; writeEnable=1 SHALL clear busy[rd]; both take effect at the edge.
REQ-030 If issueEnable and writeEnable both target the same register in one cycle, set SHALL win (busy=1; data written).
REQ-031 busyA = busy[rs], busyB = busy[rt], combinational; no bypass on busy bits.
REQ-032 Widths: busW is stored unmodified; there is no arithmetic; the pointer wraps only by leaving CLEAR.

Reset
REQ-033 Reset asserted at any edge SHALL clear all busy bits in that edge, enter CLEAR with pointer 0, and drop ready to 0 at that edge.
REQ-034 Reset held for N cycles SHALL hold the pointer at 0; the DEPTH-cycle clear starts at the first edge with reset=0.
REQ-035 Reset asserted mid-clear or mid-RUN SHALL restart the full clear sequence; no partial state survives.
REQ-036 Register contents need no reset value before the first clear completes; outputs are masked to 0 by REQ-023.

Verification
REQ-037 Reset 1 cycle, then idle -> ready=0 for exactly 32 cycles, then 1; all rs in 0..31 read 0x00000000.
REQ-038 RUN: rd=3, busW=0x01010101, writeEnable=1 for 1 cycle, rs=3 -> busA=0x01010101 same cycle (bypass) and after the edge.
REQ-039 rd=0, busW=0xFFFFFFFF, writeEnable=1; rs=0 -> busA=0x00000000 before and after the edge.
REQ-040 issueEnable, issueReg=15 -> busyA=1 for rs=15; later rd=15, busW=9, writeEnable -> busA=9, busyA=0 after the edge; same-cycle issue+write to 15 -> busyA=1, busA=9.
REQ-041 Write reg 7 = 0x12345678, assert reset at clear pointer 10 of the next clear -> ready=0 for 32 more cycles; rs=7 reads 0.
REQ-042 BYPASS=0, WIDTH=16, ADDR_BITS=3: write rd=2 0xBEEF with rs=2 -> busA shows old value 0x0000 that cycle and 0xBEEF after; ready rises after 8 cycles.
